mips_muldiv: RTL and testbench

//   Multi-cycle MIPS multiply/divide unit with HI/LO result registers, parametrised in operand width.

---
 rtl/mips_muldiv_pkg.sv | 41 ++++
 rtl/mips_muldiv_core.sv | 66 ++++++
 rtl/mips_muldiv.sv | 121 ++++++++++++
 tb/tb_mips_muldiv.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mips_muldiv_pkg.sv
// Shared opcode/funct constants and FSM state type for the MIPS multiply/divide unit.
package mips_muldiv_pkg;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1a;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } md_state_e;

  // Decoder helper for the control unit: {issue, op}; MFHI/MFLO only read hi/lo.
  function automatic logic [3:0] md_op_from_funct(input logic [5:0] funct);
    case (funct)
      FUNCT_MULT:  md_op_from_funct = {1'b1, MD_MULT};
      FUNCT_MULTU: md_op_from_funct = {1'b1, MD_MULTU};
      FUNCT_DIV:   md_op_from_funct = {1'b1, MD_DIV};
      FUNCT_DIVU:  md_op_from_funct = {1'b1, MD_DIVU};
      FUNCT_MTHI:  md_op_from_funct = {1'b1, MD_MTHI};
      FUNCT_MTLO:  md_op_from_funct = {1'b1, MD_MTLO};
      FUNCT_MFHI,
      FUNCT_MFLO:  md_op_from_funct = 4'b0000;
      default:     md_op_from_funct = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/mips_muldiv_core.sv
// Unsigned radix-2 shift-add multiply / restoring divide engine, one bit per cycle.
module mips_muldiv_core
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             en,
  output logic             last,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] sh
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] dvs;
  logic             mode_div;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  always_comb begin
    sum     = {1'b0, acc} + (sh[0] ? {1'b0, dvs} : '0);
    shifted = {acc, sh[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
  end

  assign last = (count == CW'(1));

  // acc: partial product high half / remainder; sh: multiplier then product low half / dividend then quotient
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      sh       <= '0;
      dvs      <= '0;
      mode_div <= 1'b0;
      count    <= CW'(WIDTH);
    end else if (start) begin
      acc      <= '0;
      sh       <= opa;
      dvs      <= opb;
      mode_div <= is_div;
      count    <= CW'(WIDTH);
    end else if (en) begin
      if (!last) count <= count - CW'(1);
      if (mode_div) begin
        if (!diff[WIDTH]) begin
          acc <= diff[WIDTH-1:0];
          sh  <= {sh[WIDTH-2:0], 1'b1};
        end else begin
          acc <= shifted[WIDTH-1:0];
          sh  <= {sh[WIDTH-2:0], 1'b0};
        end
      end else begin
        {acc, sh} <= {sum, sh[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/mips_muldiv.sv
// MIPS multiply/divide unit: handshake, FSM, sign conditioning/correction, HI/LO and div_zero.
module mips_muldiv
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e state, state_nx;

  logic             accept, is_md, is_mt, sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             last;
  logic [WIDTH-1:0] acc, sh;
  logic             mode_div, neg_res, neg_rem, dz_pend;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] q_fix, r_fix, fix_hi, fix_lo;

  assign req_ready = (state == ST_IDLE);
  assign busy      = ~req_ready;
  assign accept    = req_valid && req_ready;
  assign is_md     = ~op[2];
  assign is_mt     = (op == MD_MTHI) || (op == MD_MTLO);

  // Signed ops (MULT/DIV have op[0]==0) run on magnitudes; 2^(WIDTH-1) fits unsigned.
  assign sa    = ~op[0] & a[WIDTH-1];
  assign sb    = ~op[0] & b[WIDTH-1];
  assign mag_a = sa ? -a : a;
  assign mag_b = sb ? -b : b;

  mips_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept && is_md),
    .is_div (op[1]),
    .opa    (mag_a),
    .opb    (mag_b),
    .en     (state == ST_RUN),
    .last   (last),
    .acc    (acc),
    .sh     (sh)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept && is_md) state_nx = ST_RUN;
      ST_RUN:  if (last) state_nx = ST_FIX;
      ST_FIX:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Divide by zero: engine yields q=all ones, r=|a|; negating r by a's sign restores hi=a.
  always_comb begin
    prod     = {acc, sh};
    prod_fix = neg_res ? -prod : prod;
    q_fix    = neg_res ? -sh : sh;
    r_fix    = neg_rem ? -acc : acc;
    if (mode_div) begin
      fix_hi = r_fix;
      fix_lo = dz_pend ? '1 : q_fix;
    end else begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_div <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      dz_pend  <= 1'b0;
    end else if (accept && is_md) begin
      mode_div <= op[1];
      neg_res  <= sa ^ sb;
      neg_rem  <= op[1] ? sa : (sa ^ sb);
      dz_pend  <= op[1] && (b == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= (state == ST_FIX) || (accept && is_mt);
      if (state == ST_FIX) begin
        hi <= fix_hi;
        lo <= fix_lo;
        if (dz_pend) div_zero <= 1'b1;
      end
      if (accept) begin
        div_zero <= 1'b0;
        if (op == MD_MTHI) hi <= a;
        if (op == MD_MTLO) lo <= a;
      end
    end
  end

endmodule

// File: tb/tb_mips_muldiv.sv
// Scoreboard bench for mips_muldiv (WIDTH=32): directed vectors, monitor checks results and latency.
module tb_mips_muldiv;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    op = 3'b000;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          busy, done, div_zero;
  logic [W-1:0]  hi, lo;

  mips_muldiv #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           acc_cyc;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic [2*W-1:0] prev_hilo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: pops one expectation per done cycle; a done with nothing pending is an error
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (busy) chk("hilo_stable_busy", {hi, lo}, prev_hilo);
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_hi"}, 64'(hi), 64'(e.hi));
          chk({e.name, "_lo"}, 64'(lo), 64'(e.lo));
          chk({e.name, "_divzero"}, 64'(div_zero), 64'(e.dz));
          chk({e.name, "_latency"}, 64'(cyc - e.acc_cyc + 1), 64'(e.lat));
        end
      end
    end
    prev_hilo = {hi, lo};
  end

  task automatic issue(input string nm, input logic [2:0] o, input logic [W-1:0] va,
                       input logic [W-1:0] vb, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                       input logic edz, input bit expect_done, output logic done_at_acc);
    exp_t e;
    int guard = 0;
    @(negedge clk);
    req_valid = 1'b1;
    op = o;
    a = va;
    b = vb;
    while (!req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) chk({nm, "_accept_timeout"}, 64'd0, 64'd1);
    done_at_acc = done;
    if (expect_done) begin
      e.name = nm; e.hi = ehi; e.lo = elo; e.dz = edz;
      e.acc_cyc = cyc + 1;
      e.lat = (o[2] == 1'b0) ? W + 2 : 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    a = 'x;
    b = 'x;
  endtask

  task automatic wait_idle(input string nm);
    int guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) chk({nm, "_done_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic d;
    #12;
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    chk("reset_busy_ready_done_dz", {60'd0, busy, req_ready, done, div_zero}, 64'b0100);
    @(negedge clk);
    rst_n = 1'b1;

    issue("mult_m3x7", 3'b000, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1, d);
    wait_idle("mult_m3x7");
    issue("multu_ffff", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1, d);
    wait_idle("multu_ffff");
    issue("mult_m1xm1", 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0, 1, d);
    wait_idle("mult_m1xm1");
    issue("div_m7_2", 3'b010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1, d);
    wait_idle("div_m7_2");
    issue("divu_100_7", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1, d);
    wait_idle("divu_100_7");
    issue("divu_by0", 3'b011, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, 1'b1, 1, d);
    wait_idle("divu_by0");
    issue("div_min_m1", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 1, d);
    wait_idle("div_min_m1");

    issue("mthi", 3'b100, 32'h12345678, 32'h0, 32'h12345678, 32'h80000000, 1'b0, 1, d);
    wait_idle("mthi");
    issue("mtlo", 3'b101, 32'h9ABCDEF0, 32'h0, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1, d);
    wait_idle("mtlo");

    issue("reserved", 3'b110, 32'hDEADBEEF, 32'h1, 32'h0, 32'h0, 1'b0, 0, d);
    repeat (4) @(negedge clk);
    chk("reserved_hilo_kept", {hi, lo}, 64'h12345678_9ABCDEF0);
    chk("reserved_not_busy", 64'(busy), 64'd0);

    issue("mult_5x6", 3'b000, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, 1, d);
    issue("mult_held", 3'b001, 32'd7, 32'd8, 32'd0, 32'd56, 1'b0, 1, d);
    chk("held_accept_in_done_cycle", 64'(d), 64'd1);
    wait_idle("mult_held");

    issue("div_aborted", 3'b010, 32'd1000, 32'd3, 32'd0, 32'd0, 1'b0, 0, d);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_hilo", {hi, lo}, 64'd0);
    chk("async_reset_ctrl", {60'd0, busy, req_ready, done, div_zero}, 64'b0100);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue("mult_2x3_after_rst", 3'b000, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 1, d);
    wait_idle("mult_2x3_after_rst");
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
